// File: rtl/uart_apb_tx_feeder.sv
// rtl/uart_apb_tx_feeder.sv - APB master feeding a byte stream into the UART TX FIFO with credit tracking; optional UART_APB_FEEDER_TIMEOUT_EN
module uart_apb_tx_feeder #(
    parameter int                    ADDR_WIDTH     = 5,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] TX_DATA_ADDR   = 5'h10,
    parameter logic [ADDR_WIDTH-1:0] TX_COUNT_ADDR  = 5'h08,
    parameter int                    FIFO_DEPTH     = 8,
    parameter int                    POLL_GAP       = 4,
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic [7:0]              byte_i,
    input  logic                    byte_valid_i,
    output logic                    byte_ready_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i,
    output logic                    err_o,
    input  logic                    err_clr_i,
    output logic [7:0]              drop_cnt_o,
    output logic                    busy_o
);

    localparam int              CW          = $clog2(FIFO_DEPTH + 1);
    localparam int              GW          = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [CW-1:0]   CREDIT_FULL = CW'(FIFO_DEPTH);
    localparam logic [7:0]      DEPTH8      = 8'(FIFO_DEPTH);
    localparam logic [GW-1:0]   GAP_LAST    = GW'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_ACCESS,
        ST_POLL_SETUP,
        ST_POLL_ACCESS,
        ST_POLL_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      hold_q, hold_d;
    logic [CW-1:0]   credits_q, credits_d;
    logic            err_q, err_d;
    logic [7:0]      drop_q, drop_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic [7:0]      fifo_count;
    logic [CW-1:0]   poll_credits;
    logic [7:0]      drop_inc;
    logic            timeout;
    logic            unused_prdata;

    assign fifo_count    = prdata_i[7:0];
    assign unused_prdata = ^prdata_i[DATA_WIDTH-1:8];
    assign drop_inc      = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

    // Free FIFO space from the polled occupancy; an occupancy at or above depth means no room.
    always_comb begin
        poll_credits = '0;
        if (fifo_count < DEPTH8) begin
            poll_credits = CW'(DEPTH8 - fifo_count);
        end
    end

`ifdef UART_APB_FEEDER_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          in_access;

    assign in_access = (state_q == ST_WR_ACCESS) || (state_q == ST_POLL_ACCESS);
    assign timeout   = in_access && !pready_i && (tmo_q == TMO_LAST);

    // Count consecutive ACCESS cycles without pready; any other cycle restarts the count.
    always_comb begin
        tmo_d = '0;
        if (in_access && !pready_i) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout        = 1'b0;
`endif

    // Next-state, datapath updates and APB drive decoded from the current state.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        credits_d = credits_q;
        err_d     = err_q;
        drop_d    = drop_q;
        gap_d     = gap_q;
        psel_o    = 1'b0;
        penable_o = 1'b0;
        paddr_o   = '0;
        pwrite_o  = 1'b0;
        pwdata_o  = '0;
        pstrb_o   = '0;

        // A fresh error later in this block overrides the clear.
        if (err_clr_i) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (byte_valid_i) begin
                    hold_d  = byte_i;
                    state_d = (credits_q != '0) ? ST_WR_SETUP : ST_POLL_SETUP;
                end
            end
            ST_WR_SETUP: begin
                psel_o   = 1'b1;
                pwrite_o = 1'b1;
                paddr_o  = TX_DATA_ADDR;
                pwdata_o = DATA_WIDTH'(hold_q);
                pstrb_o  = '1;
                state_d  = ST_WR_ACCESS;
            end
            ST_WR_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                pwrite_o  = 1'b1;
                paddr_o   = TX_DATA_ADDR;
                pwdata_o  = DATA_WIDTH'(hold_q);
                pstrb_o   = '1;
                if (pready_i) begin
                    state_d = ST_IDLE;
                    if (pslverr_i) begin
                        err_d  = 1'b1;
                        drop_d = drop_inc;
                    end else begin
                        credits_d = credits_q - 1'b1;
                    end
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    drop_d  = drop_inc;
                end
            end
            ST_POLL_SETUP: begin
                psel_o  = 1'b1;
                paddr_o = TX_COUNT_ADDR;
                state_d = ST_POLL_ACCESS;
            end
            ST_POLL_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                paddr_o   = TX_COUNT_ADDR;
                gap_d     = '0;
                if (pready_i) begin
                    if (pslverr_i) begin
                        err_d     = 1'b1;
                        credits_d = '0;
                        state_d   = ST_POLL_WAIT;
                    end else begin
                        credits_d = poll_credits;
                        state_d   = (poll_credits != '0) ? ST_WR_SETUP : ST_POLL_WAIT;
                    end
                end else if (timeout) begin
                    err_d     = 1'b1;
                    credits_d = '0;
                    state_d   = ST_POLL_WAIT;
                end
            end
            ST_POLL_WAIT: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_POLL_SETUP;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops psel at once and discards the held byte.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            credits_q <= CREDIT_FULL;
            err_q     <= 1'b0;
            drop_q    <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            credits_q <= credits_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            gap_q     <= gap_d;
        end
    end

    assign byte_ready_o = (state_q == ST_IDLE) && !arst_i;
    assign busy_o       = (state_q != ST_IDLE);
    assign err_o        = err_q;
    assign drop_cnt_o   = drop_q;

endmodule
